vfetch_arbiter: RTL and testbench
=================================

// Module: vfetch_arbiter
// PURPOSE
//  Schedules shared framebuffer memory between video line prefetch and a host write port.
//  Sits between the 640x480 sync generator (pixel_count/line_count) and the memory controller.
//  Prefetches each visible line into a ping-pong line buffer during the preceding line.
//  Host single-word writes fill the gaps between fetch bursts.
// PARAMETERS
//  H_ACTIVE    640  visible pixels per line
//  V_ACTIVE    480  visible lines per frame
//  V_TOTAL     525  total lines per frame (active+fp+sync+bp)
//  LINE_WORDS  320  memory words per line (2 pixels/word)
//  BURST_LEN   16   words per video read burst; LINE_WORDS % BURST_LEN == 0
//  ADDR_W      22   memory word address width
//  DATA_W      16   memory data width
// PORTS
//  pixel_clock     in   1       clock; all logic on rising edge
//  reset           in   1       asynchronous, active-high
//  pixel_count     in   12      horizontal position from sync generator
//  line_count      in   12      vertical position from sync generator
//  fb_base         in   ADDR_W  frame base word address; sampled at frame boundary only
//  host_req        in   1       host write request; hold until host_gnt
//  host_addr       in   ADDR_W  host write address
//  host_wdata      in   DATA_W  host write data
//  host_gnt        out  1       1-cycle pulse: host write accepted by memory
//  mem_cmd_valid   out  1       command valid to memory controller
//  mem_cmd_ready   in   1       memory accepts command when valid&ready
//  mem_cmd_wr      out  1       1=single-word write, 0=BURST_LEN-word read
//  mem_cmd_addr    out  ADDR_W  command address
//  mem_cmd_wdata   out  DATA_W  write data (valid when mem_cmd_wr)
//  mem_rd_valid    in   1       read data beat valid
//  mem_rd_data     in   DATA_W  read data beat
//  lb_we           out  1       line buffer write enable
//  lb_addr         out  10      {bank, word index 0..LINE_WORDS-1}; bank = target line[0]
//  lb_wdata        out  DATA_W  line buffer write data (mem_rd_data, 1-cycle registered)
//  underrun        out  1       sticky: a line fetch missed its deadline
// BEHAVIOUR
//  - Reset: all outputs 0; FSM IDLE; word_addr/line_start 0; underrun cleared (reset only).
//  - Trigger: pixel_count==H_ACTIVE, target=(line_count==V_TOTAL-1)?0:line_count+1; fetch if target<V_ACTIVE.
//  - Target 0: line_start<=fb_base, word_addr<=fb_base (tear-free base change).
//  - Otherwise: line_start<=previous line_start+LINE_WORDS; word_addr<=that value.
//  - Fetch owes LINE_WORDS/BURST_LEN bursts; word_addr += BURST_LEN per accepted burst.
//  - FSM: IDLE -> VID_CMD if bursts owed, else HOST_CMD if host_req, else IDLE.
//  - VID_CMD: valid, rd, addr=word_addr; on ready -> VID_DATA.
//  - VID_DATA: count BURST_LEN beats; each beat writes lb next cycle; last beat -> IDLE.
//  - HOST_CMD: valid, wr, host addr/data; on ready, host_gnt=1 that cycle -> IDLE.
//  - Priority: video strictly over host, evaluated only in IDLE; no preemption of issued commands.
//  - mem_cmd_* stable while valid&!ready (valid/ready rules).
//  - At most one command outstanding: no new command until VID_DATA completes.
//  - Deadline: pixel_count==0 && line_count==target && bursts still owed.
//    Response: underrun<=1; drop unissued bursts; finish any in-flight burst.
//  - A new trigger arriving with bursts owed (pathological) behaves as deadline, then retargets.
//  - Line buffer word index resets to 0 per trigger, +1 per beat; no wrap within a line.
//  - Host is served only between bursts or during vertical blank; no starvation bound otherwise.
//  - Reset mid-burst: FSM to IDLE, beats in flight ignored; fetch resumes at next trigger.
// STRUCTURE
//  - Shared package vid_pkg: H_ACTIVE, V_ACTIVE, V_TOTAL, LINE_WORDS, fsm state typedef
//    (IDLE, VID_CMD, VID_DATA, HOST_CMD).
//  - Single module; no natural sub-module (arbiter, FSM and counters tightly coupled).
// TESTING
//  - Reset: assert reset mid-frame -> all outputs 0; underrun 0; next trigger fetches cleanly.
//  - Line 0 prefetch: fb_base=0x1000, line_count=524, pixel_count=640, ready tied 1, 2-cycle read latency
//    -> 20 reads at 0x1000,0x1010..0x1130; 320 lb writes to bank 0, idx 0..319.
//  - Line 1: -> reads start at 0x1140, bank 1; changing fb_base mid-frame has no effect until line 0.
//  - Host during fetch: host_req held from trigger
//    -> host_gnt only after a burst's 16th beat, before next read; all 20 bursts still issued.
//  - Backpressure: mem_cmd_ready low 100 cycles in VID_CMD -> addr/valid stable, no lb writes.
//  - Underrun: ready low until target line pixel 0
//    -> underrun=1 sticky; remaining bursts dropped; next line starts at line_start+320.

Source files
------------

// File: rtl/vid_pkg.sv
// Shared video-fetch definitions.
// Timing constants for 640x480 and the memory geometry used by the line
// prefetch arbiter, the arbiter FSM state encoding, and a helper that returns
// the line a trigger prefetches for.
package vid_pkg;

    localparam int ADDR_W = 22;
    localparam int DATA_W = 16;

    localparam logic [11:0] H_ACTIVE = 12'd640;
    localparam logic [11:0] V_ACTIVE = 12'd480;
    localparam logic [11:0] V_TOTAL  = 12'd525;

    localparam logic [ADDR_W-1:0] LINE_WORDS = 22'd320;
    localparam logic [ADDR_W-1:0] BURST_LEN  = 22'd16;

    // LINE_WORDS / BURST_LEN bursts are owed per fetched line
    localparam logic [4:0] BURSTS_PER_LINE = 5'd20;
    localparam logic [3:0] LAST_BEAT       = 4'd15;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        VID_CMD  = 2'd1,
        VID_DATA = 2'd2,
        HOST_CMD = 2'd3
    } fetch_state_t;

    // Line that will be displayed after the current one (wraps at frame end).
    function automatic logic [11:0] next_target(input logic [11:0] line);
        logic [11:0] result;
        if (line == (V_TOTAL - 12'd1)) begin
            result = 12'd0;
        end else begin
            result = line + 12'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/vfetch_arbiter.sv
// vfetch_arbiter
// Shares framebuffer memory between video line prefetch and host writes.
// At the end of each visible region (pixel_count == H_ACTIVE) the next line is
// scheduled for prefetch into a ping-pong line buffer as 16-word read bursts;
// host single-word writes are issued only when no burst is owed.
// Ports:
//   pixel_clock, reset          clock / async active-high reset
//   pixel_count, line_count     raster position from the sync generator
//   fb_base                     frame base word address (taken at line 0 only)
//   host_req/addr/wdata/gnt     host write request, gnt pulses on acceptance
//   mem_cmd_*                   command channel to the memory controller
//   mem_rd_valid/data           read data beats from the memory controller
//   lb_we/addr/wdata            line buffer write port, addr = {bank, index}
//   underrun                    sticky: a line fetch missed its deadline
module vfetch_arbiter
    import vid_pkg::*;
(
    input  logic              pixel_clock,
    input  logic              reset,
    input  logic [11:0]       pixel_count,
    input  logic [11:0]       line_count,
    input  logic [ADDR_W-1:0] fb_base,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              mem_cmd_valid,
    input  logic              mem_cmd_ready,
    output logic              mem_cmd_wr,
    output logic [ADDR_W-1:0] mem_cmd_addr,
    output logic [DATA_W-1:0] mem_cmd_wdata,
    input  logic              mem_rd_valid,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              lb_we,
    output logic [9:0]        lb_addr,
    output logic [DATA_W-1:0] lb_wdata,
    output logic              underrun
);

    fetch_state_t      state_r;
    fetch_state_t      state_s;

    logic              trig_s;
    logic              fetch_s;
    logic [11:0]       target_s;
    logic              deadline_s;
    logic              cmd_accept_s;
    logic              beat_s;

    logic [11:0]       target_r;
    logic [4:0]        owed_r;
    logic [ADDR_W-1:0] line_start_r;
    logic [ADDR_W-1:0] word_addr_r;
    logic [3:0]        beat_cnt_r;
    logic [8:0]        lb_idx_r;
    logic              bank_r;
    // command/data in flight belongs to a line that has since been retargeted
    logic              stale_r;
    logic              underrun_r;

    logic              cmd_valid_r;
    logic              cmd_wr_r;
    logic [ADDR_W-1:0] cmd_addr_r;
    logic [DATA_W-1:0] cmd_wdata_r;
    logic              cmd_valid_s;
    logic              cmd_wr_s;
    logic [ADDR_W-1:0] cmd_addr_s;
    logic [DATA_W-1:0] cmd_wdata_s;

    logic              lb_we_r;
    logic [9:0]        lb_addr_r;
    logic [DATA_W-1:0] lb_wdata_r;

    // Raster events and handshake decodes.
    always_comb begin
        trig_s       = (pixel_count == H_ACTIVE);
        target_s     = next_target(line_count);
        fetch_s      = trig_s && (target_s < V_ACTIVE);
        deadline_s   = (pixel_count == 12'd0) && (line_count == target_r) &&
                       (owed_r != 5'd0);
        cmd_accept_s = cmd_valid_r && mem_cmd_ready;
        beat_s       = (state_r == VID_DATA) && mem_rd_valid;
    end

    // FSM state register.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state: video strictly before host, decided only in IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                // a trigger cycle rewrites word_addr, so hold off issuing one cycle
                if (trig_s) begin
                    state_s = IDLE;
                end else if ((owed_r != 5'd0) && !deadline_s) begin
                    state_s = VID_CMD;
                end else if (host_req) begin
                    state_s = HOST_CMD;
                end else begin
                    state_s = IDLE;
                end
            end
            VID_CMD: begin
                if (cmd_accept_s) begin
                    state_s = VID_DATA;
                end else begin
                    state_s = VID_CMD;
                end
            end
            VID_DATA: begin
                if (beat_s && (beat_cnt_r == LAST_BEAT)) begin
                    state_s = IDLE;
                end else begin
                    state_s = VID_DATA;
                end
            end
            HOST_CMD: begin
                if (cmd_accept_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = HOST_CMD;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM outputs: command fields are captured on issue and held until accepted.
    always_comb begin
        cmd_valid_s = cmd_valid_r;
        cmd_wr_s    = cmd_wr_r;
        cmd_addr_s  = cmd_addr_r;
        cmd_wdata_s = cmd_wdata_r;
        if ((state_r == IDLE) && (state_s == VID_CMD)) begin
            cmd_valid_s = 1'b1;
            cmd_wr_s    = 1'b0;
            cmd_addr_s  = word_addr_r;
            cmd_wdata_s = {DATA_W{1'b0}};
        end else if ((state_r == IDLE) && (state_s == HOST_CMD)) begin
            cmd_valid_s = 1'b1;
            cmd_wr_s    = 1'b1;
            cmd_addr_s  = host_addr;
            cmd_wdata_s = host_wdata;
        end else if (cmd_accept_s) begin
            cmd_valid_s = 1'b0;
            cmd_wr_s    = 1'b0;
            cmd_addr_s  = {ADDR_W{1'b0}};
            cmd_wdata_s = {DATA_W{1'b0}};
        end else begin
            cmd_valid_s = cmd_valid_r;
        end
    end

    // Command output registers.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            cmd_valid_r <= 1'b0;
            cmd_wr_r    <= 1'b0;
            cmd_addr_r  <= {ADDR_W{1'b0}};
            cmd_wdata_r <= {DATA_W{1'b0}};
        end else begin
            cmd_valid_r <= cmd_valid_s;
            cmd_wr_r    <= cmd_wr_s;
            cmd_addr_r  <= cmd_addr_s;
            cmd_wdata_r <= cmd_wdata_s;
        end
    end

    // Line fetch bookkeeping: addresses, bursts owed, deadline handling.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            target_r     <= 12'd0;
            owed_r       <= 5'd0;
            line_start_r <= {ADDR_W{1'b0}};
            word_addr_r  <= {ADDR_W{1'b0}};
            bank_r       <= 1'b0;
            underrun_r   <= 1'b0;
        end else begin
            if (fetch_s) begin
                target_r <= target_s;
                bank_r   <= target_s[0];
                // base only changes at the top of the frame to avoid tearing
                if (target_s == 12'd0) begin
                    line_start_r <= fb_base;
                    word_addr_r  <= fb_base;
                end else begin
                    line_start_r <= line_start_r + LINE_WORDS;
                    word_addr_r  <= line_start_r + LINE_WORDS;
                end
            end else if (cmd_accept_s && !cmd_wr_r && !stale_r) begin
                word_addr_r <= word_addr_r + BURST_LEN;
            end else begin
                word_addr_r <= word_addr_r;
            end

            if (fetch_s) begin
                owed_r <= BURSTS_PER_LINE;
            end else if (deadline_s || trig_s) begin
                owed_r <= 5'd0;
            end else if (cmd_accept_s && !cmd_wr_r && !stale_r && (owed_r != 5'd0)) begin
                owed_r <= owed_r - 5'd1;
            end else begin
                owed_r <= owed_r;
            end

            // a trigger that finds bursts still owed is a missed deadline too
            if (deadline_s || (trig_s && (owed_r != 5'd0))) begin
                underrun_r <= 1'b1;
            end else begin
                underrun_r <= underrun_r;
            end
        end
    end

    // Burst beat counter, line buffer index and stale-burst tracking.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            beat_cnt_r <= 4'd0;
            lb_idx_r   <= 9'd0;
            stale_r    <= 1'b0;
        end else begin
            if (state_r != VID_DATA) begin
                beat_cnt_r <= 4'd0;
            end else if (beat_s) begin
                beat_cnt_r <= beat_cnt_r + 4'd1;
            end else begin
                beat_cnt_r <= beat_cnt_r;
            end

            if (fetch_s) begin
                lb_idx_r <= 9'd0;
            end else if (beat_s && !stale_r) begin
                lb_idx_r <= lb_idx_r + 9'd1;
            end else begin
                lb_idx_r <= lb_idx_r;
            end

            // a retarget while a video command is outstanding orphans its data
            if (state_s == IDLE) begin
                stale_r <= 1'b0;
            end else if (fetch_s && ((state_r == VID_CMD) || (state_r == VID_DATA))) begin
                stale_r <= 1'b1;
            end else begin
                stale_r <= stale_r;
            end
        end
    end

    // Line buffer write port, one cycle behind the read beat.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            lb_we_r    <= 1'b0;
            lb_addr_r  <= 10'd0;
            lb_wdata_r <= {DATA_W{1'b0}};
        end else begin
            lb_we_r <= beat_s && !stale_r;
            if (beat_s) begin
                lb_addr_r  <= {bank_r, lb_idx_r};
                lb_wdata_r <= mem_rd_data;
            end else begin
                lb_addr_r  <= lb_addr_r;
                lb_wdata_r <= lb_wdata_r;
            end
        end
    end

    // host_gnt must coincide with the accepting cycle so the host can drop its request
    assign host_gnt      = cmd_accept_s && cmd_wr_r;
    assign mem_cmd_valid = cmd_valid_r;
    assign mem_cmd_wr    = cmd_wr_r;
    assign mem_cmd_addr  = cmd_addr_r;
    assign mem_cmd_wdata = cmd_wdata_r;
    assign lb_we         = lb_we_r;
    assign lb_addr       = lb_addr_r;
    assign lb_wdata      = lb_wdata_r;
    assign underrun      = underrun_r;

endmodule

// File: tb/tb_vfetch_arbiter.sv
// Testbench for vfetch_arbiter: a table of prefetch triggers with hand-computed
// burst addresses and line buffer targets, followed by directed sequences for
// host arbitration, command backpressure, deadline underrun and reset mid-burst.
module tb_vfetch_arbiter;
    import vid_pkg::*;

    logic              pixel_clock = 1'b0;
    logic              reset;
    logic [11:0]       pixel_count;
    logic [11:0]       line_count;
    logic [ADDR_W-1:0] fb_base;
    logic              host_req;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic              mem_cmd_valid;
    logic              mem_cmd_ready;
    logic              mem_cmd_wr;
    logic [ADDR_W-1:0] mem_cmd_addr;
    logic [DATA_W-1:0] mem_cmd_wdata;
    logic              mem_rd_valid = 1'b0;
    logic [DATA_W-1:0] mem_rd_data  = 16'h0000;
    logic              lb_we;
    logic [9:0]        lb_addr;
    logic [DATA_W-1:0] lb_wdata;
    logic              underrun;

    always #5 pixel_clock = ~pixel_clock;

    vfetch_arbiter dut (
        .pixel_clock  (pixel_clock),
        .reset        (reset),
        .pixel_count  (pixel_count),
        .line_count   (line_count),
        .fb_base      (fb_base),
        .host_req     (host_req),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_gnt     (host_gnt),
        .mem_cmd_valid(mem_cmd_valid),
        .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_wr   (mem_cmd_wr),
        .mem_cmd_addr (mem_cmd_addr),
        .mem_cmd_wdata(mem_cmd_wdata),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data),
        .lb_we        (lb_we),
        .lb_addr      (lb_addr),
        .lb_wdata     (lb_wdata),
        .underrun     (underrun)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory model: 16 beats per accepted read, 2 cycles after acceptance,
    // data = low 16 bits of the word address.
    int unsigned       mm_delay = 0;
    int unsigned       mm_left  = 0;
    logic [DATA_W-1:0] mm_data  = 16'h0000;
    always @(posedge pixel_clock) begin
        if (mem_cmd_valid && mem_cmd_ready && !mem_cmd_wr) begin
            mm_delay     <= 1;
            mm_left      <= 16;
            mm_data      <= mem_cmd_addr[15:0];
            mem_rd_valid <= 1'b0;
        end else if (mm_delay != 0) begin
            mm_delay     <= mm_delay - 1;
            mem_rd_valid <= 1'b0;
        end else if (mm_left != 0) begin
            mem_rd_valid <= 1'b1;
            mem_rd_data  <= mm_data;
            mm_data      <= mm_data + 16'd1;
            mm_left      <= mm_left - 1;
        end else begin
            mem_rd_valid <= 1'b0;
        end
    end

    // Monitor: logs accepted reads, line buffer writes and grants.
    logic [ADDR_W-1:0] rd_log [0:1023];
    logic [9:0]        lb_alog[0:8191];
    logic [DATA_W-1:0] lb_dlog[0:8191];
    int rd_cnt  = 0;
    int lb_cnt  = 0;
    int gnt_cnt = 0;
    always @(negedge pixel_clock) begin
        #1;
        if (mem_cmd_valid && mem_cmd_ready && !mem_cmd_wr && rd_cnt < 1024) begin
            rd_log[rd_cnt] <= mem_cmd_addr;
            rd_cnt         <= rd_cnt + 1;
        end
        if (lb_we && lb_cnt < 8192) begin
            lb_alog[lb_cnt] <= lb_addr;
            lb_dlog[lb_cnt] <= lb_wdata;
            lb_cnt          <= lb_cnt + 1;
        end
        if (host_gnt) begin
            gnt_cnt <= gnt_cnt + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge pixel_clock);
    endtask

    task automatic trigger(input logic [11:0] line);
        pixel_count = 12'd640;
        line_count  = line;
        tick(1);
        pixel_count = 12'd700;
        line_count  = 12'd600;
    endtask

    task automatic check_outputs_zero(input string name);
        chk({name, " valid"}, {31'd0, mem_cmd_valid}, 32'd0);
        chk({name, " wr"}, {31'd0, mem_cmd_wr}, 32'd0);
        chk({name, " addr"}, {10'd0, mem_cmd_addr}, 32'd0);
        chk({name, " wdata"}, {16'd0, mem_cmd_wdata}, 32'd0);
        chk({name, " gnt"}, {31'd0, host_gnt}, 32'd0);
        chk({name, " lb_we"}, {31'd0, lb_we}, 32'd0);
        chk({name, " lb_addr"}, {22'd0, lb_addr}, 32'd0);
        chk({name, " underrun"}, {31'd0, underrun}, 32'd0);
    endtask

    task automatic check_fetch(input string name, input int r0, input int l0, input int n,
                               input logic [ADDR_W-1:0] first, input logic bank);
        int bad;
        logic [ADDR_W-1:0] ea;
        logic [8:0]        ki;
        logic [9:0]        la;
        logic [DATA_W-1:0] ld;
        chk({name, " bursts"}, rd_cnt - r0, n);
        chk({name, " lb writes"}, lb_cnt - l0, n * 16);
        if (n > 0) begin
            chk({name, " first addr"}, {10'd0, rd_log[r0]}, {10'd0, first});
            bad = 0;
            for (int i = 0; i < n; i++) begin
                ea = first + 22'(i * 16);
                if (rd_log[r0 + i] !== ea) bad++;
            end
            chk({name, " burst addrs"}, bad, 0);
            bad = 0;
            for (int k = 0; k < n * 16; k++) begin
                ki = k[8:0];
                la = {bank, ki};
                ld = first[15:0] + k[15:0];
                if (lb_alog[l0 + k] !== la || lb_dlog[l0 + k] !== ld) bad++;
            end
            chk({name, " lb content"}, bad, 0);
        end
    endtask

    typedef struct {
        logic [11:0]       line;
        logic [ADDR_W-1:0] fb;
        int                n;
        logic [ADDR_W-1:0] first;
        logic              bank;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int r0;
        int l0;
        int l1;
        int g0;
        int bad;
        int gnt_rd;
        int gnt_lb;
        logic gnt_seen;
        logic [ADDR_W-1:0] gnt_addr;
        logic [DATA_W-1:0] gnt_data;
        logic              gnt_wr;

        // trigger line, fb_base, bursts, first read address, bank
        vecs[0] = '{12'd524, 22'h001000, 20, 22'h001000, 1'b0};
        vecs[1] = '{12'd0,   22'h008000, 20, 22'h001140, 1'b1};
        vecs[2] = '{12'd1,   22'h008000, 20, 22'h001280, 1'b0};
        vecs[3] = '{12'd479, 22'h008000, 0,  22'h000000, 1'b0};
        vecs[4] = '{12'd523, 22'h008000, 0,  22'h000000, 1'b0};
        vecs[5] = '{12'd524, 22'h008000, 20, 22'h008000, 1'b0};
        vecs[6] = '{12'd478, 22'h008000, 20, 22'h008140, 1'b1};

        reset         = 1'b1;
        pixel_count   = 12'd700;
        line_count    = 12'd600;
        fb_base       = 22'h001000;
        host_req      = 1'b0;
        host_addr     = 22'h000000;
        host_wdata    = 16'h0000;
        mem_cmd_ready = 1'b1;
        tick(3);
        #2;
        check_outputs_zero("reset");
        tick(1);
        reset = 1'b0;
        tick(2);

        for (int v = 0; v < 7; v++) begin
            r0 = rd_cnt;
            l0 = lb_cnt;
            fb_base = vecs[v].fb;
            trigger(vecs[v].line);
            tick(700);
            check_fetch($sformatf("vec%0d", v), r0, l0, vecs[v].n, vecs[v].first, vecs[v].bank);
            chk($sformatf("vec%0d underrun", v), {31'd0, underrun}, 32'd0);
        end

        // Host held from trigger: granted only after the whole line is fetched.
        r0 = rd_cnt;
        l0 = lb_cnt;
        g0 = gnt_cnt;
        host_addr  = 22'h2AAAAA;
        host_wdata = 16'h5A5A;
        host_req   = 1'b1;
        trigger(12'd0);
        gnt_seen = 1'b0;
        gnt_rd = 0; gnt_lb = 0; gnt_addr = '0; gnt_data = '0; gnt_wr = 1'b0;
        for (int c = 0; c < 1000 && !gnt_seen; c++) begin
            @(negedge pixel_clock);
            #2;
            if (host_gnt) begin
                gnt_seen = 1'b1;
                gnt_rd   = rd_cnt - r0;
                gnt_lb   = lb_cnt - l0;
                gnt_addr = mem_cmd_addr;
                gnt_data = mem_cmd_wdata;
                gnt_wr   = mem_cmd_wr;
            end
        end
        chk("host gnt seen", {31'd0, gnt_seen}, 32'd1);
        @(negedge pixel_clock);
        host_req = 1'b0;
        chk("host gnt after bursts", gnt_rd, 20);
        chk("host gnt after beats", gnt_lb, 320);
        chk("host cmd addr", {10'd0, gnt_addr}, {10'd0, 22'h2AAAAA});
        chk("host cmd data", {16'd0, gnt_data}, 32'h5A5A);
        chk("host cmd wr", {31'd0, gnt_wr}, 32'd1);
        tick(300);
        chk("host gnt count", gnt_cnt - g0, 1);
        check_fetch("hostline", r0, l0, 20, 22'h008280, 1'b1);

        // Backpressure: command held stable, nothing written until accepted.
        mem_cmd_ready = 1'b0;
        r0 = rd_cnt;
        l0 = lb_cnt;
        trigger(12'd1);
        for (int c = 0; c < 20 && !mem_cmd_valid; c++) tick(1);
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge pixel_clock);
            #2;
            if (!(mem_cmd_valid === 1'b1 && mem_cmd_wr === 1'b0 && mem_cmd_addr === 22'h0083C0)) bad++;
        end
        chk("bp stable cmd", bad, 0);
        chk("bp no lb writes", lb_cnt - l0, 0);
        @(negedge pixel_clock);
        mem_cmd_ready = 1'b1;
        tick(700);
        check_fetch("bpline", r0, l0, 20, 22'h0083C0, 1'b0);

        // Underrun: deadline reached with the first burst still unaccepted.
        mem_cmd_ready = 1'b0;
        r0 = rd_cnt;
        l0 = lb_cnt;
        trigger(12'd2);
        tick(20);
        #2;
        chk("ur before deadline", {31'd0, underrun}, 32'd0);
        @(negedge pixel_clock);
        pixel_count = 12'd0;
        line_count  = 12'd3;
        tick(1);
        pixel_count = 12'd700;
        line_count  = 12'd600;
        #2;
        chk("ur set", {31'd0, underrun}, 32'd1);
        @(negedge pixel_clock);
        mem_cmd_ready = 1'b1;
        tick(100);
        chk("ur in-flight bursts", rd_cnt - r0, 1);
        chk("ur in-flight beats", lb_cnt - l0, 16);
        chk("ur first addr", {10'd0, rd_log[r0]}, {10'd0, 22'h008500});
        r0 = rd_cnt;
        l0 = lb_cnt;
        trigger(12'd3);
        tick(700);
        check_fetch("urnext", r0, l0, 20, 22'h008640, 1'b0);
        chk("ur sticky", {31'd0, underrun}, 32'd1);

        // Reset mid-burst: outputs clear, stray beats ignored, clean restart.
        trigger(12'd4);
        tick(50);
        reset = 1'b1;
        #2;
        check_outputs_zero("midreset");
        tick(3);
        reset = 1'b0;
        l1 = lb_cnt;
        r0 = rd_cnt;
        tick(30);
        chk("midreset stray lb", lb_cnt - l1, 0);
        chk("midreset no reads", rd_cnt - r0, 0);
        r0 = rd_cnt;
        l0 = lb_cnt;
        fb_base = 22'h001000;
        trigger(12'd524);
        tick(700);
        check_fetch("afterreset", r0, l0, 20, 22'h001000, 1'b0);
        chk("afterreset underrun", {31'd0, underrun}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
